// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: bubble encoding, default reset PC,
// fetch FSM state encoding and small PC helpers.
package rv32i_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10,
    ST_KILL  = 2'b11
  } fetch_state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Instructions are word aligned, so redirect targets drop their low two bits
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, and a cycle with no delivered
// instruction inserts a bubble while the pc fields keep their last values.
module if_id_reg
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_stall,
  input  logic        i_load,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc4,
  input  logic [31:0] i_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4,
  output logic [31:0] o_instr,
  output logic        o_valid
);

  logic [31:0] r_pc;
  logic [31:0] r_pc4;
  logic [31:0] r_instr;
  logic        r_valid;

  // Pipeline register update in flush > stall > load > bubble order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= 32'h0000_0000;
      r_pc4   <= 32'h0000_0000;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_stall) begin
      r_pc    <= r_pc;
      r_pc4   <= r_pc4;
      r_instr <= r_instr;
      r_valid <= r_valid;
    end else if (i_load) begin
      r_pc    <= i_pc;
      r_pc4   <= i_pc4;
      r_instr <= i_instr;
      r_valid <= 1'b1;
    end else begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end
  end

  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem handshake,
// stall hold buffer and branch redirect, feeding the IF/ID register.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  input  logic        i_stall_if,
  input  logic        i_flush_if,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_if_id_pc,
  output logic [31:0] o_if_id_pc4,
  output logic [31:0] o_if_id_instr,
  output logic        o_if_id_valid
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_hold_buf;
  logic [31:0]  r_redirect_pc;
  logic         r_imem_req;

  logic [31:0]  w_target;
  logic [31:0]  w_pc4;
  logic         w_deliver;
  logic [31:0]  w_deliver_instr;

  assign w_target = word_align(i_br_target);
  assign w_pc4    = pc_plus4(r_pc);

  // An instruction reaches IF/ID from the live response or from the hold buffer
  always_comb begin
    w_deliver       = 1'b0;
    w_deliver_instr = r_hold_buf;
    case (r_state)
      ST_FETCH: begin
        if (i_imem_valid && !i_br_taken && !i_stall_if) begin
          w_deliver       = 1'b1;
          w_deliver_instr = i_imem_rdata;
        end else begin
          w_deliver       = 1'b0;
        end
      end
      ST_HOLD: begin
        if (!i_br_taken && !i_stall_if) begin
          w_deliver = 1'b1;
        end else begin
          w_deliver = 1'b0;
        end
      end
      default: begin
        w_deliver = 1'b0;
      end
    endcase
  end

  // Fetch FSM; the address is the PC itself, which never moves while a
  // request is outstanding, so a redirect mid-transaction parks in KILL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_hold_buf    <= 32'h0000_0000;
      r_redirect_pc <= 32'h0000_0000;
      r_imem_req    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_FETCH;
          r_imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (i_imem_valid) begin
            if (i_br_taken) begin
              r_pc <= w_target;
            end else if (i_stall_if) begin
              r_hold_buf <= i_imem_rdata;
              r_state    <= ST_HOLD;
              r_imem_req <= 1'b0;
            end else begin
              r_pc <= w_pc4;
            end
          end else if (i_br_taken) begin
            r_redirect_pc <= w_target;
            r_state       <= ST_KILL;
          end else begin
            r_state <= ST_FETCH;
          end
        end
        ST_HOLD: begin
          if (i_br_taken) begin
            r_hold_buf <= 32'h0000_0000;
            r_pc       <= w_target;
            r_state    <= ST_FETCH;
            r_imem_req <= 1'b1;
          end else if (!i_stall_if) begin
            r_hold_buf <= 32'h0000_0000;
            r_pc       <= w_pc4;
            r_state    <= ST_FETCH;
            r_imem_req <= 1'b1;
          end else begin
            r_state <= ST_HOLD;
          end
        end
        ST_KILL: begin
          if (i_imem_valid) begin
            r_pc    <= i_br_taken ? w_target : r_redirect_pc;
            r_state <= ST_FETCH;
          end else if (i_br_taken) begin
            r_redirect_pc <= w_target;
          end else begin
            r_state <= ST_KILL;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_req  = r_imem_req;
  assign o_imem_addr = r_pc;

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (i_flush_if),
    .i_stall (i_stall_if),
    .i_load  (w_deliver),
    .i_pc    (r_pc),
    .i_pc4   (w_pc4),
    .i_instr (w_deliver_instr),
    .o_pc    (o_if_id_pc),
    .o_pc4   (o_if_id_pc4),
    .o_instr (o_if_id_instr),
    .o_valid (o_if_id_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit; memory returns addr ^ DMASK.
module tb_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] DMASK = 32'hA5C3_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        stall_if = 1'b0;
  logic        flush_if = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] if_id_pc, if_id_pc4, if_id_instr;
  logic        if_id_valid;

  int n_vec  = 0;
  int n_miss = 0;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_br_taken    (br_taken),
    .i_br_target   (br_target),
    .i_stall_if    (stall_if),
    .i_flush_if    (flush_if),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_valid  (imem_valid),
    .i_imem_rdata  (imem_rdata),
    .o_if_id_pc    (if_id_pc),
    .o_if_id_pc4   (if_id_pc4),
    .o_if_id_instr (if_id_instr),
    .o_if_id_valid (if_id_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        br;
    logic [31:0] tgt;
    logic        st;
    logic        fl;
    logic        req;
    logic [31:0] addr;
    logic        ifv;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] ins;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic br, input logic [31:0] tgt,
                              input logic st, input logic fl, input logic req,
                              input logic [31:0] addr, input logic ifv,
                              input logic [31:0] pc, input logic [31:0] pc4,
                              input logic [31:0] ins);
    vec_t r;
    r.v = v; r.br = br; r.tgt = tgt; r.st = st; r.fl = fl;
    r.req = req; r.addr = addr; r.ifv = ifv; r.pc = pc; r.pc4 = pc4; r.ins = ins;
    return r;
  endfunction

  task automatic check(input string name, input logic req, input logic [31:0] addr,
                       input logic ifv, input logic [31:0] pc, input logic [31:0] pc4,
                       input logic [31:0] ins);
    n_vec++;
    if (imem_req !== req || imem_addr !== addr || if_id_valid !== ifv ||
        if_id_pc !== pc || if_id_pc4 !== pc4 || if_id_instr !== ins) begin
      n_miss++;
      $display("FAIL %s: got req=%0b addr=%h v=%0b pc=%h pc4=%h instr=%h, want req=%0b addr=%h v=%0b pc=%h pc4=%h instr=%h",
               name, imem_req, imem_addr, if_id_valid, if_id_pc, if_id_pc4, if_id_instr,
               req, addr, ifv, pc, pc4, ins);
    end
  endtask

  task automatic drive(input logic v, input logic br, input logic [31:0] tgt,
                       input logic st, input logic fl);
    imem_valid = v;
    br_taken   = br;
    br_target  = tgt;
    stall_if   = st;
    flush_if   = fl;
    imem_rdata = imem_addr ^ DMASK;
  endtask

  initial begin
    // inputs for cycle c | outputs observed in cycle c
    tbl.push_back(mk(1,0,32'h0,0,0, 0,32'h0,       0,32'h0,       32'h0,   NOP));
    tbl.push_back(mk(1,0,32'h0,0,0, 1,32'h0,       0,32'h0,       32'h0,   NOP));
    tbl.push_back(mk(1,0,32'h0,0,0, 1,32'h4,       1,32'h0,       32'h4,   32'hA5C3_0000));
    tbl.push_back(mk(1,0,32'h0,0,0, 1,32'h8,       1,32'h4,       32'h8,   32'hA5C3_0004));
    tbl.push_back(mk(1,0,32'h0,0,0, 1,32'hC,       1,32'h8,       32'hC,   32'hA5C3_0008));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,32'h10,      1,32'hC,       32'h10,  32'hA5C3_000C));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,32'h10,      0,32'hC,       32'h10,  NOP));
    tbl.push_back(mk(1,0,32'h0,0,0, 1,32'h10,      0,32'hC,       32'h10,  NOP));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,32'h14,      1,32'h10,      32'h14,  32'hA5C3_0010));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,32'h14,      0,32'h10,      32'h14,  NOP));
    tbl.push_back(mk(1,0,32'h0,0,0, 1,32'h14,      0,32'h10,      32'h14,  NOP));
    tbl.push_back(mk(0,1,32'h103,0,0, 1,32'h18,    1,32'h14,      32'h18,  32'hA5C3_0014));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,32'h18,      0,32'h14,      32'h18,  NOP));
    tbl.push_back(mk(1,0,32'h0,0,0, 1,32'h18,      0,32'h14,      32'h18,  NOP));
    tbl.push_back(mk(1,0,32'h0,0,0, 1,32'h100,     0,32'h14,      32'h18,  NOP));
    tbl.push_back(mk(1,0,32'h0,1,0, 1,32'h104,     1,32'h100,     32'h104, 32'hA5C3_0100));
    tbl.push_back(mk(1,0,32'h0,1,0, 0,32'h104,     1,32'h100,     32'h104, 32'hA5C3_0100));
    tbl.push_back(mk(0,0,32'h0,1,0, 0,32'h104,     1,32'h100,     32'h104, 32'hA5C3_0100));
    tbl.push_back(mk(0,0,32'h0,1,0, 0,32'h104,     1,32'h100,     32'h104, 32'hA5C3_0100));
    tbl.push_back(mk(0,0,32'h0,0,0, 0,32'h104,     1,32'h100,     32'h104, 32'hA5C3_0100));
    tbl.push_back(mk(1,0,32'h0,0,0, 1,32'h108,     1,32'h104,     32'h108, 32'hA5C3_0104));
    tbl.push_back(mk(1,0,32'h0,1,0, 1,32'h10C,     1,32'h108,     32'h10C, 32'hA5C3_0108));
    tbl.push_back(mk(0,1,32'h200,1,1, 0,32'h10C,   1,32'h108,     32'h10C, 32'hA5C3_0108));
    tbl.push_back(mk(1,0,32'h0,0,0, 1,32'h200,     0,32'h108,     32'h10C, NOP));
    tbl.push_back(mk(1,1,32'h300,0,0, 1,32'h204,   1,32'h200,     32'h204, 32'hA5C3_0200));
    tbl.push_back(mk(1,0,32'h0,0,0, 1,32'h300,     0,32'h200,     32'h204, NOP));
    tbl.push_back(mk(1,1,32'hFFFF_FFFE,0,0, 1,32'h304, 1,32'h300, 32'h304, 32'hA5C3_0300));
    tbl.push_back(mk(1,0,32'h0,0,0, 1,32'hFFFF_FFFC, 0,32'h300,   32'h304, NOP));
    tbl.push_back(mk(1,0,32'h0,0,1, 1,32'h0,       1,32'hFFFF_FFFC, 32'h0, 32'h5A3C_FFFC));
    tbl.push_back(mk(1,0,32'h0,0,0, 1,32'h4,       0,32'hFFFF_FFFC, 32'h0, NOP));
    tbl.push_back(mk(0,0,32'h0,1,0, 1,32'h8,       1,32'h4,       32'h8,   32'hA5C3_0004));
    tbl.push_back(mk(0,1,32'h40,0,0, 1,32'h8,      1,32'h4,       32'h8,   32'hA5C3_0004));
    tbl.push_back(mk(0,1,32'h80,0,0, 1,32'h8,      0,32'h4,       32'h8,   NOP));
    tbl.push_back(mk(1,0,32'h0,0,0, 1,32'h8,       0,32'h4,       32'h8,   NOP));
    tbl.push_back(mk(1,0,32'h0,0,0, 1,32'h80,      0,32'h4,       32'h8,   NOP));
    tbl.push_back(mk(0,0,32'h0,0,0, 1,32'h84,      1,32'h80,      32'h84,  32'hA5C3_0080));

    repeat (2) @(negedge clk);
    check("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, NOP);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      check($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].ifv,
            tbl[i].pc, tbl[i].pc4, tbl[i].ins);
      drive(tbl[i].v, tbl[i].br, tbl[i].tgt, tbl[i].st, tbl[i].fl);
      @(negedge clk);
    end

    // Async reset with a response pending; the response must be ignored after it
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, NOP);
    @(negedge clk);
    rst_n = 1'b1;
    check("idle_after_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, NOP);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("first_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, NOP);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("first_load", 1'b1, 32'h4, 1'b1, 32'h0, 32'h4, 32'hA5C3_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
